pc_sequencer: RTL



---
 rtl/pc_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program sequencer for the 8-puzzle solver core. Walks the instruction ROM,
// resolves JMP/JNZ locally using a flag latched from the datapath, and hands
// every other opcode to the datapath. Execution stops at FIN_ADDR, or when the
// retired-instruction budget runs out.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse; begins execution at START_ADDR (IDLE or HALT only)
//   pc         instruction address to ROM
//   op         instruction from ROM, combinational from pc
//   exec_req   datapath instruction request
//   exec_op    instruction presented to datapath
//   exec_ack   datapath completion
//   exec_flag  datapath result flag
//   busy       high in FETCH/EXEC (decoded from state)
//   halted     high in HALT after reaching FIN_ADDR
//   timeout    high in HALT after the step budget ran out
//   steps      retired instruction count, saturating
//
// Datapath handshake: exec_req acts as valid and exec_ack as ready. Once
// exec_req rises, it and exec_op stay constant until a cycle in which
// exec_req && exec_ack is sampled at the clock edge; exactly that cycle
// completes the transfer, and exec_flag is captured only then. exec_ack may
// already be high in the first exec_req cycle. exec_ack in any other cycle
// has no effect.

module pc_sequencer #(
    parameter logic [3:0]  JMP_OPC    = 4'hE,
    parameter logic [3:0]  JNZ_OPC    = 4'hF,
    parameter logic [7:0]  FIN_ADDR   = 8'd199,
    parameter logic [7:0]  START_ADDR = 8'd0,
    parameter logic [15:0] MAX_STEPS  = 16'd60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  pc,
    input  logic [15:0] op,
    output logic        exec_req,
    output logic [15:0] exec_op,
    input  logic        exec_ack,
    input  logic        exec_flag,
    output logic        busy,
    output logic        halted,
    output logic        timeout,
    output logic [15:0] steps
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [7:0]  pc_n;
    logic        exec_req_n;
    logic [15:0] exec_op_n;
    logic        flag, flag_n;
    logic        halted_n;
    logic        timeout_n;
    logic [15:0] steps_n;
    logic [15:0] steps_inc;
    logic [3:0]  opcode;

    assign opcode    = op[15:12];
    // Count saturates rather than wrapping so a runaway program is still visible.
    assign steps_inc = (steps == 16'hFFFF) ? steps : steps + 16'd1;
    assign busy      = (state == FETCH) || (state == EXEC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= START_ADDR;
            exec_req <= 1'b0;
            exec_op  <= 16'd0;
            flag     <= 1'b0;
            halted   <= 1'b0;
            timeout  <= 1'b0;
            steps    <= 16'd0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            exec_req <= exec_req_n;
            exec_op  <= exec_op_n;
            flag     <= flag_n;
            halted   <= halted_n;
            timeout  <= timeout_n;
            steps    <= steps_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        exec_req_n = exec_req;
        exec_op_n  = exec_op;
        flag_n     = flag;
        halted_n   = halted;
        timeout_n  = timeout;
        steps_n    = steps;

        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_n   = FETCH;
                    pc_n      = START_ADDR;
                    steps_n   = 16'd0;
                    flag_n    = 1'b0;
                    halted_n  = 1'b0;
                    timeout_n = 1'b0;
                end
            end

            FETCH: begin
                // FIN beats the budget: a program landing on FIN exactly as the
                // budget runs out still reports a normal finish.
                if (pc == FIN_ADDR) begin
                    state_n  = HALT;
                    halted_n = 1'b1;
                end else if (steps == MAX_STEPS) begin
                    state_n   = HALT;
                    timeout_n = 1'b1;
                end else if (opcode == JMP_OPC) begin
                    pc_n    = op[7:0];
                    steps_n = steps_inc;
                end else if (opcode == JNZ_OPC) begin
                    pc_n    = flag ? op[7:0] : pc + 8'd1;
                    steps_n = steps_inc;
                end else begin
                    // Instruction retires when it is issued; the ack only
                    // advances the pc and refreshes the flag.
                    state_n    = EXEC;
                    exec_op_n  = op;
                    exec_req_n = 1'b1;
                    steps_n    = steps_inc;
                end
            end

            EXEC: begin
                if (exec_ack) begin
                    state_n    = FETCH;
                    flag_n     = exec_flag;
                    exec_req_n = 1'b0;
                    pc_n       = pc + 8'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
